// File: rtl/popcount_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : popcount_sequencer
// Purpose  : Multi-cycle population counter. Accepts a 4*NIBBLES-bit word
//            over a valid/ready handshake, walks it LSB-first one nibble per
//            clock through a single shared 4-bit ones-count stage, and
//            presents the accumulated total over a second valid/ready
//            handshake.
// Ports    : clk        - clock, all state updates on the rising edge
//            rst_n      - asynchronous, active-low reset
//            in_valid   - in_data holds a word to count
//            in_ready   - block can accept a word (IDLE only)
//            in_data    - word to count, sampled on accept
//            out_valid  - out_count holds a finished result (DONE only)
//            out_ready  - consumer takes the result
//            out_count  - number of 1 bits in the accepted word
//            out_zero   - out_count == 0
//            busy       - a word is being counted or waiting to be taken
// Revision : 1.0 - initial release
// ============================================================================
module popcount_sequencer #(
   parameter  int NIBBLES = 8,
   localparam int DATA_W  = 4 * NIBBLES,
   localparam int CNT_W   = $clog2(4 * NIBBLES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_zero,
   output logic              busy
);

   // Nibble index needs at least one bit even when there is a single nibble.
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [DATA_W-1:0]  r_sh;
   logic [CNT_W-1:0]   r_acc;
   logic [IDX_W-1:0]   r_idx;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [CNT_W-1:0]   r_out_count;
   logic               r_out_zero;

   logic [2:0]         w_pc;
   logic [CNT_W-1:0]   w_sum;
   logic               w_last;

   // Ones count of a single nibble, 0..4.
   function automatic logic [2:0] pc4(input logic [3:0] nib);
      return 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
   endfunction

   // Shared counting stage: always looks at the lowest nibble of the
   // shift register; the register moves the next nibble down each cycle.
   assign w_pc   = pc4(r_sh[3:0]);
   assign w_sum  = r_acc + CNT_W'(w_pc);
   assign w_last = (r_idx == c_last_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_sh        <= '0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_out_count <= '0;
         r_out_zero  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_sh       <= in_data;
                  r_acc      <= '0;
                  r_idx      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_RUN;
               end
            end

            ST_RUN: begin
               r_acc <= w_sum;
               r_sh  <= r_sh >> 4;
               r_idx <= r_idx + IDX_W'(1);
               if (w_last) begin
                  // The result is captured separately from the accumulator
                  // so it survives the next accept (which clears r_acc).
                  r_out_count <= w_sum;
                  r_out_zero  <= (w_sum == '0);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Handshake and status outputs come straight from registers, so neither
   // in_valid nor out_ready has a combinational path to any output.
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign out_count = r_out_count;
   assign out_zero  = r_out_zero;

endmodule
`default_nettype wire
